// File: rtl/arb_pkg.sv
// Shared types and default constants for the three-channel arbiter request controller.
package arb_pkg;

  localparam int LEN_W_DEF   = 4;
  localparam int TMO_CYC_DEF = 15;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    XFER = 2'd2,
    REL  = 2'd3
  } chan_state_e;

endpackage

// File: rtl/arb_req_chan.sv
// One request channel: turns a start pulse into a granted burst of beats toward the arbiter.
// Optional WAIT timeout is compiled in with REQ_TIMEOUT_EN.
//
// state | meaning
// IDLE  | no transfer; a req pulse starts one
// WAIT  | requesting, no beat granted yet
// XFER  | requesting, at least one beat done
// REL   | request dropped; leaves once grant is seen low
module arb_req_chan
  import arb_pkg::*;
#(
  parameter int LEN_W   = LEN_W_DEF,
  parameter int TMO_CYC = TMO_CYC_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req,
  input  logic [LEN_W-1:0] len,
  input  logic             g,
  output logic             r,
  output logic             done,
  output logic             drop,
  output logic             err
);

  chan_state_e      st, st_nxt;
  logic [LEN_W-1:0] cnt, cnt_nxt;
  logic [LEN_W-1:0] len_eff;
  logic             beat_last;
  logic             done_nxt;
  logic             tmo_hit;

  assign len_eff   = (len == '0) ? LEN_W'(1) : len;
  assign beat_last = (cnt == LEN_W'(1));

  always_comb begin
    st_nxt   = st;
    cnt_nxt  = cnt;
    done_nxt = 1'b0;
    case (st)
      IDLE: begin
        if (req) begin
          st_nxt  = WAIT;
          cnt_nxt = len_eff;
        end
      end
      WAIT: begin
        if (g) begin
          cnt_nxt = cnt - LEN_W'(1);
          if (beat_last) begin
            st_nxt   = REL;
            done_nxt = 1'b1;
          end else begin
            st_nxt = XFER;
          end
        end else if (tmo_hit) begin
          st_nxt = REL;
        end
      end
      XFER: begin
        if (g) begin
          cnt_nxt = cnt - LEN_W'(1);
          if (beat_last) begin
            st_nxt   = REL;
            done_nxt = 1'b1;
          end
        end
      end
      REL: begin
        if (!g) st_nxt = IDLE;
      end
      default: st_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      st   <= IDLE;
      cnt  <= '0;
      r    <= 1'b0;
      done <= 1'b0;
      drop <= 1'b0;
    end else begin
      st   <= st_nxt;
      cnt  <= cnt_nxt;
      r    <= (st_nxt == WAIT) || (st_nxt == XFER);
      done <= done_nxt;
      drop <= req && (st != IDLE);
    end
  end

`ifdef REQ_TIMEOUT_EN
  localparam int TMO_W = (TMO_CYC < 2) ? 1 : $clog2(TMO_CYC + 1);

  logic [TMO_W-1:0] tmo_cnt;

  // Down-counter reloads outside WAIT; a grant in the terminal cycle wins over the abandon.
  assign tmo_hit = (tmo_cnt == TMO_W'(1));

  always_ff @(posedge clk) begin
    if (reset) begin
      tmo_cnt <= '0;
      err     <= 1'b0;
    end else begin
      err <= (st == WAIT) && !g && tmo_hit;
      if (st != WAIT) tmo_cnt <= TMO_W'(TMO_CYC);
      else if (!g)    tmo_cnt <= tmo_cnt - TMO_W'(1);
    end
  end
`else
  assign tmo_hit = 1'b0;
  assign err     = 1'b0;
`endif

endmodule

// File: rtl/arb_req_ctrl.sv
// Three independent request channels in front of a fixed-priority arbiter (device 1 highest).
// Define REQ_TIMEOUT_EN to abandon requests left ungranted for TMO_CYC WAIT cycles.
module arb_req_ctrl
  import arb_pkg::*;
#(
  parameter int LEN_W   = LEN_W_DEF,
  parameter int TMO_CYC = TMO_CYC_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:1]       req_i,
  input  logic [LEN_W-1:0] len1_i,
  input  logic [LEN_W-1:0] len2_i,
  input  logic [LEN_W-1:0] len3_i,
  input  logic [3:1]       g_i,
  output logic [3:1]       r_o,
  output logic [3:1]       done_o,
  output logic [3:1]       drop_o,
  output logic [3:1]       err_o
);

  arb_req_chan #(.LEN_W(LEN_W), .TMO_CYC(TMO_CYC)) u_chan1 (
    .clk   (clk),
    .reset (reset),
    .req   (req_i[1]),
    .len   (len1_i),
    .g     (g_i[1]),
    .r     (r_o[1]),
    .done  (done_o[1]),
    .drop  (drop_o[1]),
    .err   (err_o[1])
  );

  arb_req_chan #(.LEN_W(LEN_W), .TMO_CYC(TMO_CYC)) u_chan2 (
    .clk   (clk),
    .reset (reset),
    .req   (req_i[2]),
    .len   (len2_i),
    .g     (g_i[2]),
    .r     (r_o[2]),
    .done  (done_o[2]),
    .drop  (drop_o[2]),
    .err   (err_o[2])
  );

  arb_req_chan #(.LEN_W(LEN_W), .TMO_CYC(TMO_CYC)) u_chan3 (
    .clk   (clk),
    .reset (reset),
    .req   (req_i[3]),
    .len   (len3_i),
    .g     (g_i[3]),
    .r     (r_o[3]),
    .done  (done_o[3]),
    .drop  (drop_o[3]),
    .err   (err_o[3])
  );

endmodule

// File: tb/tb_arb_req_ctrl.sv
// Scoreboard bench for arb_req_ctrl with a registered fixed-priority arbiter attached.
// Timeout expectations follow REQ_TIMEOUT_EN.
module tb_arb_req_ctrl;

  localparam int LEN_W = 4;
  localparam int TMO   = 4;
`ifdef REQ_TIMEOUT_EN
  localparam bit TMO_ON = 1'b1;
`else
  localparam bit TMO_ON = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [3:1]       req_i = '0;
  logic [LEN_W-1:0] len1_i = '0, len2_i = '0, len3_i = '0;
  logic [3:1]       g_i;
  logic [3:1]       r_o, done_o, drop_o, err_o;

  always #5 clk = ~clk;

  arb_req_ctrl #(.LEN_W(LEN_W), .TMO_CYC(TMO)) dut (
    .clk    (clk),
    .reset  (reset),
    .req_i  (req_i),
    .len1_i (len1_i),
    .len2_i (len2_i),
    .len3_i (len3_i),
    .g_i    (g_i),
    .r_o    (r_o),
    .done_o (done_o),
    .drop_o (drop_o),
    .err_o  (err_o)
  );

  // Registered priority arbiter: grant follows last cycle's request vector.
  always @(posedge clk) begin
    if (reset)         g_i <= 3'b000;
    else if (r_o[1])   g_i <= 3'b001;
    else if (r_o[2])   g_i <= 3'b010;
    else if (r_o[3])   g_i <= 3'b100;
    else               g_i <= 3'b000;
  end

  typedef struct {
    logic [3:1] r;
    logic [3:1] done;
    logic [3:1] drop;
    logic [3:1] err;
  } exp_t;

  exp_t sbq[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc = 0;

  // Reference: phase 0 idle, 1 requesting/no beat yet, 2 requesting/mid burst, 3 releasing.
  int ph[1:3];
  int rem[1:3];
  int waited[1:3];

  task automatic model_push();
    exp_t e;
    e.r = '0; e.done = '0; e.drop = '0; e.err = '0;
    if (reset) begin
      for (int i = 1; i <= 3; i++) begin
        ph[i] = 0; rem[i] = 0; waited[i] = 0;
      end
    end else begin
      for (int i = 1; i <= 3; i++) begin
        int ln;
        bit rq, gg;
        ln = (i == 1) ? int'(len1_i) : (i == 2) ? int'(len2_i) : int'(len3_i);
        rq = req_i[i];
        gg = g_i[i];
        if (rq && ph[i] != 0) e.drop[i] = 1'b1;
        case (ph[i])
          0: if (rq) begin
               ph[i] = 1; rem[i] = (ln == 0) ? 1 : ln; waited[i] = 0;
             end
          1, 2: begin
            if (gg) begin
              rem[i] = rem[i] - 1;
              if (rem[i] == 0) begin ph[i] = 3; e.done[i] = 1'b1; end
              else ph[i] = 2;
            end else if (ph[i] == 1 && TMO_ON) begin
              waited[i] = waited[i] + 1;
              if (waited[i] == TMO) begin ph[i] = 3; e.err[i] = 1'b1; end
            end
          end
          default: if (!gg) ph[i] = 0;
        endcase
        e.r[i] = (ph[i] == 1 || ph[i] == 2);
      end
    end
    sbq.push_back(e);
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (sbq.size() > 0) begin
      e = sbq.pop_front();
      n_checks++;
      if (r_o !== e.r) begin
        n_errors++;
        $display("FAIL sb_r cyc %0d: got %b exp %b", cyc, r_o, e.r);
      end
      n_checks++;
      if (done_o !== e.done) begin
        n_errors++;
        $display("FAIL sb_done cyc %0d: got %b exp %b", cyc, done_o, e.done);
      end
      n_checks++;
      if (drop_o !== e.drop) begin
        n_errors++;
        $display("FAIL sb_drop cyc %0d: got %b exp %b", cyc, drop_o, e.drop);
      end
      n_checks++;
      if (err_o !== e.err) begin
        n_errors++;
        $display("FAIL sb_err cyc %0d: got %b exp %b", cyc, err_o, e.err);
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
    model_push();
    @(posedge clk);
    #1;
    cyc++;
    req_i = '0;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d exp %0d", nm, act, exp);
    end
  endtask

  initial begin
    int dcnt[1:3];
    int first[1:3];
    int late_done;

    idle(3);
    chk("reset_r", int'(r_o), 0);
    chk("reset_done_drop_err", int'({done_o, drop_o, err_o}), 0);
    reset = 1'b0;
    idle(2);

    // Single device, len 3, then a req in the REL->IDLE cycle
    req_i = 3'b001; len1_i = 4'd3; step();
    chk("s30_r_t1", int'(r_o[1]), 1);
    step(); chk("s30_g_t2", int'(g_i[1]), 1);
    step(); chk("s30_g_t3", int'(g_i[1]), 1);
    step(); chk("s30_g_t4", int'(g_i[1]), 1);
    step();
    chk("s30_done_t5", int'(done_o[1]), 1);
    chk("s30_r_low_t5", int'(r_o[1]), 0);
    step();
    req_i = 3'b001; len1_i = 4'd2; step();
    chk("s20_drop_rel_exit", int'(drop_o[1]), 1);
    chk("s20_no_wait", int'(r_o[1]), 0);
    idle(8);

    // All three at once, len 2
    req_i = 3'b111; len1_i = 4'd2; len2_i = 4'd2; len3_i = 4'd2;
    for (int i = 1; i <= 3; i++) begin dcnt[i] = 0; first[i] = -1; end
    for (int k = 1; k <= 20; k++) begin
      step();
      chk("s31_g_onehot", int'(g_i == 3'b000 || g_i == 3'b001 || g_i == 3'b010 || g_i == 3'b100), 1);
      for (int i = 1; i <= 3; i++) if (done_o[i]) begin
        dcnt[i]++;
        if (first[i] < 0) first[i] = k;
      end
    end
    chk("s31_done1_once", dcnt[1], 1);
    chk("s31_done2_once", dcnt[2], 1);
    chk("s31_done3_once", dcnt[3], 1);
    chk("s31_order_1_2", int'(first[1] < first[2]), 1);
    chk("s31_order_2_3", int'(first[2] < first[3]), 1);
    idle(6);

    // Second req on device 2 mid-transfer is dropped, burst length unchanged
    req_i = 3'b010; len2_i = 4'd5; step();
    step(); step();
    req_i = 3'b010; len2_i = 4'd1; step();
    chk("s32_drop_t4", int'(drop_o[2]), 1);
    chk("s32_r_t4", int'(r_o[2]), 1);
    chk("s32_done_t4", int'(done_o[2]), 0);
    for (int k = 5; k <= 7; k++) begin
      step();
      chk($sformatf("s32_done_t%0d", k), int'(done_o[2]), (k == 7) ? 1 : 0);
    end
    idle(8);

    // len 0 behaves as a single beat
    req_i = 3'b001; len1_i = 4'd0; step();
    step(); step();
    chk("s33_done_t3", int'(done_o[1]), 1);
    chk("s33_r_t3", int'(r_o[1]), 0);
    idle(8);

    // Reset during device 3 transfer
    req_i = 3'b100; len3_i = 4'd8;
    idle(4);
    reset = 1'b1; step(); reset = 1'b0;
    chk("s34_all_zero", int'({r_o, done_o, drop_o, err_o}), 0);
    late_done = 0;
    for (int k = 0; k < 12; k++) begin
      step();
      if (done_o[3]) late_done++;
    end
    chk("s34_no_done3", late_done, 0);

`ifdef REQ_TIMEOUT_EN
    // Device 3 starved by a long device 1 burst
    req_i = 3'b001; len1_i = 4'd15; step();
    req_i = 3'b100; len3_i = 4'd3; step();
    step(); step(); step();
    chk("s35_err_t5_quiet", int'(err_o[3]), 0);
    step();
    chk("s35_err_t6", int'(err_o[3]), 1);
    chk("s35_r3_low", int'(r_o[3]), 0);
    chk("s35_no_done3", int'(done_o[3]), 0);
    idle(20);
`endif

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      for (int b = 1; b <= 3; b++) req_i[b] = ($urandom_range(0, 3) == 0);
      len1_i = LEN_W'($urandom_range(0, 15));
      len2_i = LEN_W'($urandom_range(0, 15));
      len3_i = LEN_W'($urandom_range(0, 15));
      reset  = ($urandom_range(0, 299) == 0);
      step();
      reset = 1'b0;
    end
    idle(30);
    @(negedge clk);
    #1;
    chk("sb_drained", sbq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/arb_req_ctrl.md
ARB_REQ_CTRL -- requirements
Module: arb_req_ctrl

Interface
REQ-001 SHALL have parameter LEN_W, default 4, giving the width of the transfer-length field.
REQ-002 SHALL have parameter TMO_CYC, default 15, giving the number of un-granted WAIT cycles before abandon (used only with REQ_TIMEOUT_EN).
REQ-003 SHALL have port clk  input  1  as the single clock; all logic is on its rising edge.
REQ-004 SHALL have port reset  input  1  as the reset, synchronous and active-high.
REQ-005 SHALL have port req_i  input  [3:1]  as per-device one-cycle start pulses.
REQ-006 SHALL have ports len1_i, len2_i, len3_i  input  LEN_W each  as per-device beat counts, sampled on that device's accepted req_i pulse.
REQ-007 SHALL have port g_i  input  [3:1]  as the grant vector from the priority arbiter.
REQ-008 SHALL have port r_o  output  [3:1]  as the request vector to the priority arbiter.
REQ-009 SHALL have port done_o  output  [3:1]  as per-device one-cycle pulses marking transfer completion.
REQ-010 SHALL have port drop_o  output  [3:1]  as per-device one-cycle pulses marking req_i ignored because the channel was not IDLE.
REQ-011 SHALL have port err_o  output  [3:1]  as per-device one-cycle pulses marking timeout abandon; tied 0 without REQ_TIMEOUT_EN.

Function
REQ-012 SHALL run three independent channels, one per device; each channel is a 4-state FSM: IDLE, WAIT, XFER, REL.
REQ-013 In IDLE, SHALL go to WAIT on req_i[i]=1 and load the beat counter with len (len=0 treated as 1).
REQ-014 SHALL drive r_o[i]=1 exactly in WAIT and XFER, registered, and r_o[i]=0 in IDLE and REL.
REQ-015 In WAIT with g_i[i]=1, SHALL count that cycle as beat 1 and move to XFER, or to REL if len=1.
REQ-016 In XFER, SHALL count one beat per cycle with g_i[i]=1 and stall the count while g_i[i]=0.
REQ-017 After the final beat, SHALL enter REL next cycle and pulse done_o[i] in the first REL cycle.
REQ-018 In REL, SHALL ignore g_i[i] for beat counting and return to IDLE on the cycle after g_i[i] is sampled 0, so r_o[i] is held low for at least one cycle.
REQ-019 SHALL ignore req_i[i] in any state other than IDLE and pulse drop_o[i] the next cycle; counter and state are unchanged.
REQ-020 A req_i[i] pulse arriving in the cycle REL→IDLE occurs SHALL be dropped.
REQ-021 SHALL keep channels independent: simultaneous pulses on several req_i bits are all accepted, and arbiter priority (1>2>3) alone decides grant order.
REQ-022 Latency: req pulse at cycle t SHALL give r_o high at t+1.

Reset
REQ-023 On reset=1 at a clock edge, every channel SHALL enter IDLE, clear its counters, and drive r_o, done_o, drop_o and err_o to 0 next cycle.
REQ-024 Reset asserted mid-XFER SHALL abandon the transfer without a done_o pulse.

Configuration
REQ-025 When REQ_TIMEOUT_EN is defined, each channel SHALL count consecutive WAIT cycles with g_i[i]=0, and on reaching TMO_CYC SHALL go to REL and pulse err_o[i] with no done_o.
REQ-026 With REQ_TIMEOUT_EN defined, g_i[i]=1 in the same cycle as the timeout SHALL win, giving normal beat 1 and no err_o.
REQ-027 When REQ_TIMEOUT_EN is undefined, WAIT SHALL persist indefinitely, err_o SHALL be constant 0, and no timeout counter SHALL exist.

Structure
REQ-028 Package arb_pkg SHALL hold the channel state enum (IDLE, WAIT, XFER, REL) and default constants for LEN_W and TMO_CYC.
REQ-029 Sub-module arb_req_chan SHALL implement one channel and be instantiated three times.

Verification
REQ-030 Scenario: req_i=001, len1=3, arbiter attached → r_o[1] high t+1, grants at t+2..t+4, done_o[1] at t+5, r_o[1] low from t+5.
REQ-031 Scenario: req_i=111, all len=2 → device 1 served first, then 2, then 3; each done_o fires once; no overlapping g_i.
REQ-032 Scenario: second req_i[2] pulse during device 2 XFER → drop_o[2] pulse; beat count unaffected.
REQ-033 Scenario: len1=0 → exactly one beat, then done_o[1].
REQ-034 Scenario: reset during XFER of device 3 → all outputs 0 next cycle, no done_o[3].
REQ-035 Scenario (REQ_TIMEOUT_EN, TMO_CYC=4): device 3 starved by continuous device 1 traffic → err_o[3] after 4 WAIT cycles; r_o[3] drops.
